// File: rtl/voice_freq_scheduler.sv
// Round-robin arbiter sharing one multi-cycle note/octave->frequency unit among NUM_VOICES voices.
// Request-to-ack latency is 3 cycles minimum, one grant per 4 cycles; VOICE_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module voice_freq_scheduler #(
   parameter int NUM_VOICES     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_VOICES-1:0]     voice_req,
   input  logic [4*NUM_VOICES-1:0]   voice_note,
   input  logic [3*NUM_VOICES-1:0]   voice_octave,
   output logic [NUM_VOICES-1:0]     voice_ack,
   output logic [NUM_VOICES-1:0]     voice_err,
   output logic [16*NUM_VOICES-1:0]  voice_freq,
   output logic                      fu_start,
   output logic [3:0]                fu_note,
   output logic [2:0]                fu_octave,
   input  logic                      fu_done,
   input  logic [15:0]               fu_frequency,
   output logic                      busy
);

   localparam int GW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                          state_q, state_d;
   logic [NUM_VOICES-1:0]           pend_q, pend_d;
   logic [NUM_VOICES-1:0][3:0]      slot_note_q, slot_note_d;
   logic [NUM_VOICES-1:0][2:0]      slot_oct_q, slot_oct_d;
   logic [NUM_VOICES-1:0][15:0]     freq_q, freq_d;
   logic [GW-1:0]                   grant_q, grant_d;
   logic [GW-1:0]                   last_q, last_d;
   logic                            keep_q, keep_d;
   logic [NUM_VOICES-1:0]           ack_q, ack_d;
   logic [NUM_VOICES-1:0]           err_q, err_d;
   logic                            start_q, start_d;
   logic [3:0]                      fnote_q, fnote_d;
   logic [2:0]                      foct_q, foct_d;
   logic                            busy_q, busy_d;
`ifdef VOICE_SCHED_TIMEOUT_EN
   logic [7:0]                      cnt_q, cnt_d;
`endif

   logic [NUM_VOICES-1:0]           req_ok;
   logic                            found;
   logic [GW-1:0]                   pick;
   logic [GW-1:0]                   idx;

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      slot_note_d = slot_note_q;
      slot_oct_d  = slot_oct_q;
      freq_d      = freq_q;
      grant_d     = grant_q;
      last_d      = last_q;
      keep_d      = keep_q;
      ack_d       = '0;
      err_d       = '0;
      start_d     = 1'b0;
      fnote_d     = fnote_q;
      foct_d      = foct_q;
`ifdef VOICE_SCHED_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      req_ok = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         req_ok[i] = voice_req[i] && (voice_note[4*i +: 4] <= 4'd11);
      end

      // Round-robin search starting just after the last voice served.
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_VOICES; k++) begin
         idx = GW'((int'(last_q) + k) % NUM_VOICES);
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = pick;
               fnote_d = slot_note_q[pick];
               foct_d  = slot_oct_q[pick];
               keep_d  = 1'b0;
               start_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef VOICE_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (fu_done) begin
               freq_d[grant_q] = fu_frequency;
               ack_d[grant_q]  = 1'b1;
               state_d         = S_DONE;
            end
`ifdef VOICE_SCHED_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               err_d[grant_q] = 1'b1;
               if (!keep_q) pend_d[grant_q] = 1'b0;
               last_d  = grant_q;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_DONE: begin
            if (!keep_q) pend_d[grant_q] = 1'b0;
            last_d  = grant_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // New requests land after the clear so a re-request always survives.
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (voice_req[i] && !req_ok[i]) err_d[i] = 1'b1;
         if (req_ok[i]) begin
            pend_d[i]      = 1'b1;
            slot_note_d[i] = voice_note[4*i +: 4];
            slot_oct_d[i]  = voice_octave[3*i +: 3];
            if ((state_q != S_IDLE && grant_q == GW'(i)) ||
                (state_q == S_IDLE && found && pick == GW'(i)))
               keep_d = 1'b1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pend_q      <= '0;
         slot_note_q <= '0;
         slot_oct_q  <= '0;
         freq_q      <= '0;
         grant_q     <= '0;
         last_q      <= GW'(NUM_VOICES - 1);
         keep_q      <= 1'b0;
         ack_q       <= '0;
         err_q       <= '0;
         start_q     <= 1'b0;
         fnote_q     <= '0;
         foct_q      <= '0;
         busy_q      <= 1'b0;
`ifdef VOICE_SCHED_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         slot_note_q <= slot_note_d;
         slot_oct_q  <= slot_oct_d;
         freq_q      <= freq_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         keep_q      <= keep_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         start_q     <= start_d;
         fnote_q     <= fnote_d;
         foct_q      <= foct_d;
         busy_q      <= busy_d;
`ifdef VOICE_SCHED_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign voice_ack  = ack_q;
   assign voice_err  = err_q;
   assign voice_freq = freq_q;
   assign fu_start   = start_q;
   assign fu_note    = fnote_q;
   assign fu_octave  = foct_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_voice_freq_scheduler.sv
// Bench for voice_freq_scheduler: directed scenarios plus a randomized run against a timeline model.
module tb_voice_freq_scheduler;
   localparam int N  = 4;
   localparam int TO = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     voice_req;
   logic [4*N-1:0]   voice_note;
   logic [3*N-1:0]   voice_octave;
   logic [N-1:0]     voice_ack;
   logic [N-1:0]     voice_err;
   logic [16*N-1:0]  voice_freq;
   logic             fu_start;
   logic [3:0]       fu_note;
   logic [2:0]       fu_octave;
   logic             fu_done;
   logic [15:0]      fu_frequency;
   logic             busy;

   voice_freq_scheduler #(.NUM_VOICES(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .voice_req(voice_req), .voice_note(voice_note),
      .voice_octave(voice_octave), .voice_ack(voice_ack), .voice_err(voice_err),
      .voice_freq(voice_freq), .fu_start(fu_start), .fu_note(fu_note),
      .fu_octave(fu_octave), .fu_done(fu_done), .fu_frequency(fu_frequency), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Timeline model: a grant at edge c with unit delay d gives ack after edge c+d+1,
   // slot release at edge c+d+2, and the next decision no earlier than edge c+d+3.
   int           e_cnt = 0;
   bit           m_act;
   int           m_c, m_d, m_nd, m_cur, m_last;
   bit           m_keep;
   bit           m_pend[N];
   int           m_note[N], m_oct[N];
   int           g_note, g_oct;
   logic [15:0]  exp_freq[N];
   logic [N-1:0] exp_ack, exp_err;
   bit           exp_start, exp_busy;
   int           d_fix = 1;
   bit           force_done = 0;
   logic [15:0]  force_val = '0;
   bit           spurious_en = 0;

   function automatic logic [15:0] fmodel(int n, int o);
      return 16'(440 + (n - 9) * 50 + (o - 4) * 1000);
   endfunction

   function automatic logic [16*N-1:0] exp_freq_vec();
      logic [16*N-1:0] v;
      for (int i = 0; i < N; i++) v[16*i +: 16] = exp_freq[i];
      return v;
   endfunction

   task automatic model_reset();
      m_act = 0; m_nd = 0; m_last = N - 1; m_keep = 0; m_c = 0; m_d = 1; m_cur = 0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_note[i] = 0; m_oct[i] = 0; exp_freq[i] = '0;
      end
      exp_ack = '0; exp_err = '0; exp_start = 0; exp_busy = 0;
   endtask

   task automatic set_req(int i, int n, int o);
      voice_req[i]            = 1'b1;
      voice_note[4*i +: 4]    = 4'(n);
      voice_octave[3*i +: 3]  = 3'(o);
   endtask

   task automatic cycle();
      int e;
      int nxt;
      bit found;
      nxt = e_cnt + 1;
      fu_done = 1'b0;
      fu_frequency = 16'($urandom);
      if (m_act && nxt == m_c + m_d + 1) begin
         fu_done = 1'b1;
         fu_frequency = fmodel(g_note, g_oct);
      end else if (force_done) begin
         fu_done = 1'b1;
         fu_frequency = force_val;
      end else if (spurious_en && (!m_act || nxt == m_c + 1 || nxt == m_c + m_d + 2)
                   && $urandom_range(0, 3) == 0) begin
         fu_done = 1'b1;
      end
      @(posedge clk);
      e_cnt++;
      e = e_cnt;
      exp_ack = '0; exp_err = '0; exp_start = 0;
      if (reset) begin
         model_reset();
      end else begin
         if (m_act && e == m_c + m_d + 1) begin
            exp_freq[m_cur] = fmodel(g_note, g_oct);
            exp_ack[m_cur] = 1'b1;
         end
         if (m_act && e == m_c + m_d + 2) begin
            if (!m_keep) m_pend[m_cur] = 0;
            m_last = m_cur;
            m_act = 0;
         end
         if (!m_act && e >= m_nd) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               if (!found && m_pend[(m_last + k) % N]) begin
                  found = 1; m_cur = (m_last + k) % N;
               end
            end
            if (found) begin
               g_note = m_note[m_cur]; g_oct = m_oct[m_cur];
               m_c = e; m_d = (d_fix != 0) ? d_fix : int'($urandom_range(1, 3));
               m_keep = 0; m_act = 1; m_nd = e + m_d + 3; exp_start = 1;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (voice_req[i]) begin
               if (voice_note[4*i +: 4] >= 4'd12) exp_err[i] = 1'b1;
               else begin
                  m_pend[i] = 1; m_note[i] = int'(voice_note[4*i +: 4]);
                  m_oct[i] = int'(voice_octave[3*i +: 3]);
                  if (m_act && i == m_cur) m_keep = 1;
               end
            end
         end
         exp_busy = m_act && (e <= m_c + m_d + 1);
      end
      #1;
      voice_req = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1; cycle(); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cycle(); cycle();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (voice_freq !== '0) begin errors++; $display("FAIL reset_freq got=%h want=0", voice_freq); end
      checks++; if (voice_ack !== '0 || voice_err !== '0) begin errors++; $display("FAIL reset_ack_err got=%b/%b want=0/0", voice_ack, voice_err); end
      checks++; if (fu_start !== 1'b0 || fu_note !== 4'd0 || fu_octave !== 3'd0) begin errors++; $display("FAIL reset_fu got=%b/%0d/%0d want=0/0/0", fu_start, fu_note, fu_octave); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      d_fix = 1; do_reset();
      set_req(2, 9, 4); cycle();
      checks++; if (fu_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_e0 got start=%b busy=%b want 0/0", fu_start, busy); end
      cycle();
      checks++; if (fu_start !== 1'b1 || fu_note !== 4'd9 || fu_octave !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL single_start got=%b/%0d/%0d/%b want=1/9/4/1", fu_start, fu_note, fu_octave, busy); end
      cycle();
      checks++; if (fu_start !== 1'b0 || voice_ack !== '0) begin errors++; $display("FAIL single_wait got start=%b ack=%b want 0/0", fu_start, voice_ack); end
      cycle();
      checks++; if (voice_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b want=0100", voice_ack); end
      checks++; if (voice_freq !== {16'd0, 16'd440, 16'd0, 16'd0}) begin errors++; $display("FAIL single_freq got=%h want=%h", voice_freq, {16'd0, 16'd440, 16'd0, 16'd0}); end
      cycle(); cycle();
      checks++; if (voice_ack !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_after got ack=%b busy=%b want 0/0", voice_ack, busy); end
   endtask

   task automatic test_burst();
      int snotes[$];
      int at[$];
      logic [N-1:0] av[$];
      int first2;
      d_fix = 1; do_reset();
      for (int i = 0; i < N; i++) set_req(i, i + 1, i);
      cycle();
      for (int t = 1; t <= 20; t++) begin
         cycle();
         if (fu_start) snotes.push_back(int'(fu_note));
         if (voice_ack != '0) begin at.push_back(t); av.push_back(voice_ack); end
      end
      checks++;
      if (snotes.size() != N || av.size() != N) begin
         errors++; $display("FAIL burst_count got starts=%0d acks=%0d want=%0d", snotes.size(), av.size(), N);
      end else begin
         for (int i = 0; i < N; i++) begin
            checks++;
            if (snotes[i] != i + 1 || av[i] !== N'(1 << i) || at[i] != 3 + 4 * i) begin
               errors++; $display("FAIL burst_order%0d got note=%0d ack=%b t=%0d want note=%0d ack=%b t=%0d",
                                  i, snotes[i], av[i], at[i], i + 1, N'(1 << i), 3 + 4 * i);
            end
         end
      end
      for (int i = 0; i < N; i++) set_req(i, 10 - i, 1);
      cycle();
      first2 = -1;
      for (int t = 0; t < 6; t++) begin
         cycle();
         if (fu_start && first2 < 0) first2 = int'(fu_note);
      end
      checks++; if (first2 != 10) begin errors++; $display("FAIL burst_wrap got first note=%0d want=10", first2); end
   endtask

   task automatic test_bad_note();
      int starts;
      d_fix = 1; do_reset();
      set_req(1, 12, 3); cycle();
      checks++; if (voice_err !== 4'b0010) begin errors++; $display("FAIL bad_err got=%b want=0010", voice_err); end
      starts = 0;
      for (int t = 0; t < 5; t++) begin cycle(); if (fu_start || busy) starts++; end
      checks++; if (starts != 0 || voice_err !== '0) begin errors++; $display("FAIL bad_nogrant got active=%0d err=%b want 0/0000", starts, voice_err); end
      set_req(3, 15, 0); set_req(0, 11, 7); cycle();
      checks++; if (voice_err !== 4'b1000) begin errors++; $display("FAIL bad_mixed_err got=%b want=1000", voice_err); end
      cycle();
      checks++; if (fu_start !== 1'b1 || fu_note !== 4'd11 || fu_octave !== 3'd7) begin errors++; $display("FAIL bad_mixed_grant got=%b/%0d/%0d want=1/11/7", fu_start, fu_note, fu_octave); end
   endtask

   task automatic test_rerequest();
      int acks;
      int sn[$];
      logic [15:0] f0[$];
      d_fix = 3; do_reset();
      set_req(0, 5, 2); cycle(); cycle(); cycle();
      set_req(0, 3, 1); cycle();
      acks = 0;
      for (int t = 0; t < 14; t++) begin
         cycle();
         if (fu_start) sn.push_back(int'(fu_note) * 8 + int'(fu_octave));
         if (voice_ack != '0) begin acks++; f0.push_back(voice_freq[15:0]); end
      end
      checks++;
      if (acks != 2 || sn.size() != 1) begin
         errors++; $display("FAIL rereq_count got acks=%0d starts=%0d want 2/1", acks, sn.size());
      end else begin
         checks++; if (f0[0] !== fmodel(5, 2)) begin errors++; $display("FAIL rereq_first got=%0d want=%0d", f0[0], fmodel(5, 2)); end
         checks++; if (sn[0] != 3 * 8 + 1) begin errors++; $display("FAIL rereq_second_note got=%0d want=%0d", sn[0], 25); end
         checks++; if (f0[1] !== fmodel(3, 1)) begin errors++; $display("FAIL rereq_second got=%0d want=%0d", f0[1], fmodel(3, 1)); end
      end
   endtask

   task automatic test_reset_in_wait();
      int bad;
      d_fix = 50; do_reset();
      set_req(3, 7, 6); cycle(); cycle(); cycle();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rwait_busy got=%b want=1", busy); end
      reset = 1'b1; cycle(); reset = 1'b0;
      force_done = 1; force_val = 16'd1234; cycle(); force_done = 0;
      checks++; if (voice_ack !== '0 || voice_freq !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rwait_abort got ack=%b freq=%h busy=%b want 0/0/0", voice_ack, voice_freq, busy); end
      bad = 0;
      for (int t = 0; t < 6; t++) begin cycle(); if (voice_ack != '0 || fu_start || busy) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL rwait_idle got active=%0d want=0", bad); end
   endtask

   task automatic test_random();
      d_fix = 0; do_reset(); spurious_en = 1;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
         cycle();
         checks++; if (fu_start !== exp_start) begin errors++; $display("FAIL rnd_start t=%0d got=%b want=%b", t, fu_start, exp_start); end
         if (exp_start) begin
            checks++; if (fu_note !== 4'(g_note) || fu_octave !== 3'(g_oct)) begin errors++; $display("FAIL rnd_fu t=%0d got=%0d/%0d want=%0d/%0d", t, fu_note, fu_octave, g_note, g_oct); end
         end
         checks++; if (voice_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack t=%0d got=%b want=%b", t, voice_ack, exp_ack); end
         checks++; if (voice_err !== exp_err) begin errors++; $display("FAIL rnd_err t=%0d got=%b want=%b", t, voice_err, exp_err); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy t=%0d got=%b want=%b", t, busy, exp_busy); end
         checks++; if (voice_freq !== exp_freq_vec()) begin errors++; $display("FAIL rnd_freq t=%0d got=%h want=%h", t, voice_freq, exp_freq_vec()); end
      end
      spurious_en = 0;
   endtask

`ifdef VOICE_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      d_fix = 1000; do_reset();
      set_req(1, 2, 2); set_req(2, 4, 3); cycle(); cycle();
      checks++; if (fu_start !== 1'b1 || fu_note !== 4'd2) begin errors++; $display("FAIL to_grant got=%b/%0d want=1/2", fu_start, fu_note); end
      bad = 0;
      for (int j = 1; j <= 9; j++) begin
         cycle();
         if (j < 9 && voice_err != '0) bad++;
         if (voice_ack != '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL to_early got=%0d want=0", bad); end
      checks++; if (voice_err !== 4'b0010 || voice_freq !== '0) begin errors++; $display("FAIL to_err got err=%b freq=%h want 0010/0", voice_err, voice_freq); end
      cycle();
      checks++; if (fu_start !== 1'b1 || fu_note !== 4'd4 || fu_octave !== 3'd3) begin errors++; $display("FAIL to_next got=%b/%0d/%0d want=1/4/3", fu_start, fu_note, fu_octave); end
   endtask
`endif

   initial begin
      reset = 1'b1; voice_req = '0; voice_note = '0; voice_octave = '0;
      fu_done = 1'b0; fu_frequency = '0;
      model_reset();
      test_reset();
      test_single();
      test_burst();
      test_bad_note();
      test_rerequest();
      test_reset_in_wait();
      test_random();
`ifdef VOICE_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
